qiangda_round_ctrl: RTL and testbench
=====================================

# qiangda_round_ctrl

Round sequencer and buzzer arbiter for the four-player quiz buzzer system. Debounces the four active-low player keys, arbitrates the first valid press, flags early presses (fouls), and runs the arm-window and answer countdowns in two-digit BCD. Its outputs feed the 7-segment scan/decode logic and the player LEDs; the host operates it with `start`/`stop`.

## Interface
Parameters:
- TICK_DIV, 100000: clk100khz cycles per countdown tick (1 Hz at 100 kHz).
- DB_CYCLES, 1000: consecutive stable samples needed to accept a key level change (10 ms).
- ARM_SEC, 5: arm-window length in seconds, 0..99.
- ANS_SEC, 30: answer-time length in seconds, 0..99.

Ports:
- clk100khz  in  1  sole clock.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  host start, active-high; rising edge acts.
- stop  in  1  host abort, active-high level.
- key_n  in  4  player keys, active-low; key_n[0] = player 1 … key_n[3] = player 4.
- winner  out  3  winning player 1..4; 0 = none.
- led  out  4  winner LED: player1 4'b1000, p2 4'b0100, p3 4'b0010, p4 4'b0001; 0 = none.
- foul  out  3  first player to press while IDLE, 1..4; 0 = none.
- cnt_ten  out  4  countdown tens digit, BCD.
- cnt_one  out  4  countdown ones digit, BCD.
- state  out  2  0 IDLE, 1 ARMED, 2 ANSWER, 3 DONE.
- timeout  out  1  high in DONE when reached by countdown expiry.

## Operation
- Key path per bit: 2-flop synchronizer, then debounce counter; debounced level changes only after DB_CYCLES consecutive identical synchronized samples. Press event = debounced level going 1→0, one cycle wide. Held keys generate no further events.
- Multiple press events in one cycle: lowest index wins (player 1 highest priority).
- Prescaler counts 0..TICK_DIV-1; tick = one-cycle pulse at terminal count. Cleared on every countdown load.
- BCD decrement: ones 0 → 9 with tens−1; otherwise ones−1. Counter never goes below 00.
- IDLE: counter shows ARM_SEC, no ticking. Press event with foul==0 latches foul (later presses ignored). Start edge → ARMED, load ARM_SEC, clear winner, led, foul, timeout.
- ARMED: tick decrements. Press event → ANSWER, latch winner/led, load ANS_SEC. Tick with counter 00 → DONE, timeout=1, winner stays 0.
- ANSWER: tick decrements; tick with counter 00 → DONE, timeout=1. Presses ignored; winner/led held.
- DONE: counter frozen. Presses ignored. Start edge → ARMED exactly as from IDLE.
- Priority within a cycle: stop > start edge > press event > tick.
- stop (any state): → IDLE next edge; clear winner, led, foul, timeout; load ARM_SEC; clear prescaler. Start edges ignored while stop high.

## Timing
- Reset (clr low, async): state IDLE, winner 0, led 0, foul 0, timeout 0, counter = ARM_SEC, prescaler 0, debounced levels 1 (released), start edge detector 0. Reset mid-round aborts with no residual winner.
- key_n falling and stable → press event 2+DB_CYCLES cycles later; winner/led/state/foul registered on the following edge.
- start edge detected from registered start; state changes on the edge after start is first sampled high.
- First decrement after load occurs TICK_DIV cycles after the load edge. Timeout = (N+1) ticks after load of N; with N=0 timeout on first tick.
- All outputs registered; no combinational input-to-output paths.

## Test plan
(Bench: TICK_DIV=10, DB_CYCLES=4, ARM_SEC=5, ANS_SEC=30.)
- Reset, no stimulus → state 0, cnt 0/5, winner 0, led 0, foul 0, timeout 0.
- start pulse, key_n[2] low at 8 cycles → state 2, winner 3, led 4'b0010, cnt 3/0; after 10 more cycles cnt 2/9; 31st tick → state 3, timeout 1.
- key_n[1] and key_n[3] fall same cycle while ARMED → winner 2, led 4'b0100; key_n[0] 4 cycles later ignored.
- key_n[0] low in IDLE → foul 1; held through start → no win; release/re-press ≥4 cycles each → winner 1, foul cleared at start.
- ARMED, no press: cnt 05→00 over 5 ticks, 6th tick → state 3, timeout 1, winner 0; 2-cycle key glitch never registers.
- stop during ANSWER, and clr low mid-ARMED → both give state 0, winner 0, led 0, cnt 0/5; start then restarts normally.

Source files
------------

// File: rtl/qiangda_round_ctrl.sv
// qiangda_round_ctrl: round sequencer and buzzer arbiter for a four-player quiz system.
// Debounces active-low player keys, arbitrates the first press, flags early presses
// as fouls and runs the arm-window / answer countdowns in two-digit BCD.
module qiangda_round_ctrl #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned DB_CYCLES = 1000,
    parameter int unsigned ARM_SEC   = 5,
    parameter int unsigned ANS_SEC   = 30
) (
    input  logic       clk100khz,
    input  logic       clr,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] key_n,
    output logic [2:0] winner,
    output logic [3:0] led,
    output logic [2:0] foul,
    output logic [3:0] cnt_ten,
    output logic [3:0] cnt_one,
    output logic [1:0] state,
    output logic       timeout
);

    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam int unsigned DW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [3:0] ARM_TEN = 4'(ARM_SEC / 10);
    localparam logic [3:0] ARM_ONE = 4'(ARM_SEC % 10);
    localparam logic [3:0] ANS_TEN = 4'(ANS_SEC / 10);
    localparam logic [3:0] ANS_ONE = 4'(ANS_SEC % 10);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ANSWER = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic [3:0]    sync_a, sync_b;
    logic [3:0]    db_level, db_prev;
    logic [DW-1:0] db_cnt [4];
    logic [3:0]    press;
    logic          press_any;
    logic [2:0]    press_id;
    logic [3:0]    press_led;

    logic          start_q, start_d, start_edge;
    logic [PW-1:0] presc;
    logic          counting, tick, cnt_zero;

    logic          load_arm, load_ans, dec, set_to, latch_win, latch_foul, clr_all;

    // Two-flop synchronizer and per-key debounce counter; level flips after DB_CYCLES agreeing samples
    always_ff @(posedge clk100khz or negedge clr) begin
        if (!clr) begin
            sync_a   <= '1;
            sync_b   <= '1;
            db_level <= '1;
            db_prev  <= '1;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_a  <= key_n;
            sync_b  <= sync_a;
            db_prev <= db_level;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync_b[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync_b[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = db_prev & ~db_level;

    // Fixed-priority arbitration: player 1 beats higher-numbered players in the same cycle
    always_comb begin
        press_any = |press;
        press_id  = 3'd0;
        press_led = 4'b0000;
        if (press[0]) begin
            press_id  = 3'd1;
            press_led = 4'b1000;
        end else if (press[1]) begin
            press_id  = 3'd2;
            press_led = 4'b0100;
        end else if (press[2]) begin
            press_id  = 3'd3;
            press_led = 4'b0010;
        end else if (press[3]) begin
            press_id  = 3'd4;
            press_led = 4'b0001;
        end
    end

    // Registered start and its delayed copy for rising-edge detection
    always_ff @(posedge clk100khz or negedge clr) begin
        if (!clr) begin
            start_q <= 1'b0;
            start_d <= 1'b0;
        end else begin
            start_q <= start;
            start_d <= start_q;
        end
    end

    assign start_edge = start_q & ~start_d;
    assign counting   = (cur_state == ARMED) || (cur_state == ANSWER);
    assign tick       = counting && (presc == PRESC_LAST);
    assign cnt_zero   = (cnt_ten == 4'd0) && (cnt_one == 4'd0);

    // State register
    always_ff @(posedge clk100khz or negedge clr) begin
        if (!clr) cur_state <= IDLE;
        else      cur_state <= nxt_state;
    end

    // Next-state logic: stop > start edge > press > tick
    always_comb begin
        nxt_state = cur_state;
        if (stop) begin
            nxt_state = IDLE;
        end else if (start_edge && (cur_state == IDLE || cur_state == DONE)) begin
            nxt_state = ARMED;
        end else begin
            case (cur_state)
                ARMED: begin
                    if (press_any)           nxt_state = ANSWER;
                    else if (tick && cnt_zero) nxt_state = DONE;
                end
                ANSWER: if (tick && cnt_zero) nxt_state = DONE;
                default: ;
            endcase
        end
    end

    // Output/control decode: datapath actions for this cycle, same priority as the state logic
    always_comb begin
        load_arm   = 1'b0;
        load_ans   = 1'b0;
        dec        = 1'b0;
        set_to     = 1'b0;
        latch_win  = 1'b0;
        latch_foul = 1'b0;
        clr_all    = 1'b0;
        if (stop) begin
            load_arm = 1'b1;
            clr_all  = 1'b1;
        end else if (start_edge && (cur_state == IDLE || cur_state == DONE)) begin
            load_arm = 1'b1;
            clr_all  = 1'b1;
        end else begin
            case (cur_state)
                IDLE: if (press_any && foul == 3'd0) latch_foul = 1'b1;
                ARMED: begin
                    if (press_any) begin
                        latch_win = 1'b1;
                        load_ans  = 1'b1;
                    end else if (tick) begin
                        if (cnt_zero) set_to = 1'b1;
                        else          dec    = 1'b1;
                    end
                end
                ANSWER: begin
                    if (tick) begin
                        if (cnt_zero) set_to = 1'b1;
                        else          dec    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Prescaler, BCD countdown and registered result outputs
    always_ff @(posedge clk100khz or negedge clr) begin
        if (!clr) begin
            presc   <= '0;
            cnt_ten <= ARM_TEN;
            cnt_one <= ARM_ONE;
            winner  <= 3'd0;
            led     <= 4'b0000;
            foul    <= 3'd0;
            timeout <= 1'b0;
        end else begin
            if (load_arm || load_ans || !counting || tick) presc <= '0;
            else                                          presc <= presc + 1'b1;

            if (load_arm) begin
                cnt_ten <= ARM_TEN;
                cnt_one <= ARM_ONE;
            end else if (load_ans) begin
                cnt_ten <= ANS_TEN;
                cnt_one <= ANS_ONE;
            end else if (dec) begin
                if (cnt_one == 4'd0) begin
                    cnt_ten <= cnt_ten - 4'd1;
                    cnt_one <= 4'd9;
                end else begin
                    cnt_one <= cnt_one - 4'd1;
                end
            end

            if (clr_all) begin
                winner <= 3'd0;
                led    <= 4'b0000;
            end else if (latch_win) begin
                winner <= press_id;
                led    <= press_led;
            end

            if (clr_all)         foul <= 3'd0;
            else if (latch_foul) foul <= press_id;

            if (clr_all)     timeout <= 1'b0;
            else if (set_to) timeout <= 1'b1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_qiangda_round_ctrl.sv
// Directed bench for qiangda_round_ctrl with short tick and debounce periods.
module tb_qiangda_round_ctrl;

    logic       clk100khz = 1'b0;
    logic       clr       = 1'b0;
    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic [3:0] key_n     = 4'hF;
    logic [2:0] winner;
    logic [3:0] led;
    logic [2:0] foul;
    logic [3:0] cnt_ten;
    logic [3:0] cnt_one;
    logic [1:0] state;
    logic       timeout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    qiangda_round_ctrl #(
        .TICK_DIV (10),
        .DB_CYCLES(4),
        .ARM_SEC  (5),
        .ANS_SEC  (30)
    ) dut (
        .clk100khz(clk100khz),
        .clr      (clr),
        .start    (start),
        .stop     (stop),
        .key_n    (key_n),
        .winner   (winner),
        .led      (led),
        .foul     (foul),
        .cnt_ten  (cnt_ten),
        .cnt_one  (cnt_one),
        .state    (state),
        .timeout  (timeout)
    );

    always #5 clk100khz = ~clk100khz;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk100khz);
        #1;
    endtask

    // One-cycle start pulse; returns just after the edge that loads ARMED
    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] exp);
        check(tag, {cnt_ten, cnt_one}, exp);
    endtask

    initial begin
        // Reset
        cyc(3);
        clr = 1'b1;
        cyc(2);
        check("rst_state", 8'(state), 8'd0);
        check_cnt("rst_cnt", 8'h05);
        check("rst_winner", 8'(winner), 8'd0);
        check("rst_led", 8'(led), 8'd0);
        check("rst_foul", 8'(foul), 8'd0);
        check("rst_timeout", 8'(timeout), 8'd0);

        // Start ignored while stop is high
        stop = 1'b1;
        pulse_start();
        check("stop_blocks_start", 8'(state), 8'd0);
        stop = 1'b0;
        cyc(3);
        check("stop_blocks_start2", 8'(state), 8'd0);

        // Single winner, answer countdown to timeout
        pulse_start();
        check("t2_armed", 8'(state), 8'd1);
        check_cnt("t2_arm_cnt", 8'h05);
        cyc(6);
        key_n[2] = 1'b0;
        cyc(7);
        check("t2_state", 8'(state), 8'd2);
        check("t2_winner", 8'(winner), 8'd3);
        check("t2_led", 8'(led), 8'b0010);
        check_cnt("t2_cnt30", 8'h30);
        cyc(10);
        check_cnt("t2_cnt29", 8'h29);
        cyc(299);
        check("t2_pre_state", 8'(state), 8'd2);
        check_cnt("t2_pre_cnt", 8'h00);
        check("t2_pre_timeout", 8'(timeout), 8'd0);
        cyc(1);
        check("t2_done", 8'(state), 8'd3);
        check("t2_timeout", 8'(timeout), 8'd1);
        check("t2_winner_hold", 8'(winner), 8'd3);
        key_n[2] = 1'b1;
        cyc(10);
        check_cnt("t2_frozen", 8'h00);

        // Simultaneous presses from DONE restart; player 2 beats player 4
        pulse_start();
        check("t3_armed", 8'(state), 8'd1);
        check("t3_winner_clr", 8'(winner), 8'd0);
        check("t3_timeout_clr", 8'(timeout), 8'd0);
        check_cnt("t3_cnt", 8'h05);
        key_n[1] = 1'b0;
        key_n[3] = 1'b0;
        cyc(7);
        check("t3_state", 8'(state), 8'd2);
        check("t3_winner", 8'(winner), 8'd2);
        check("t3_led", 8'(led), 8'b0100);
        key_n[0] = 1'b0;
        cyc(10);
        check("t3_late_winner", 8'(winner), 8'd2);
        check("t3_late_led", 8'(led), 8'b0100);

        // Stop during ANSWER
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_state", 8'(state), 8'd0);
        check("stop_winner", 8'(winner), 8'd0);
        check("stop_led", 8'(led), 8'd0);
        check_cnt("stop_cnt", 8'h05);
        key_n = 4'hF;
        cyc(8);
        check("stop_no_foul", 8'(foul), 8'd0);

        // Foul in IDLE, held through start, then release and re-press
        key_n[0] = 1'b0;
        cyc(7);
        check("t4_foul", 8'(foul), 8'd1);
        check("t4_idle", 8'(state), 8'd0);
        key_n[1] = 1'b0;
        cyc(7);
        check("t4_foul_keep", 8'(foul), 8'd1);
        key_n[1] = 1'b1;
        cyc(8);
        pulse_start();
        check("t4_armed", 8'(state), 8'd1);
        check("t4_foul_clr", 8'(foul), 8'd0);
        cyc(8);
        check("t4_held_state", 8'(state), 8'd1);
        check("t4_held_winner", 8'(winner), 8'd0);
        key_n[0] = 1'b1;
        cyc(6);
        key_n[0] = 1'b0;
        cyc(7);
        check("t4_state", 8'(state), 8'd2);
        check("t4_winner", 8'(winner), 8'd1);
        check("t4_led", 8'(led), 8'b1000);
        check("t4_foul", 8'(foul), 8'd0);
        check_cnt("t4_cnt", 8'h30);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        key_n = 4'hF;
        cyc(8);

        // ARMED expiry with a 2-cycle glitch that must not register
        pulse_start();
        key_n[3] = 1'b0;
        cyc(2);
        key_n[3] = 1'b1;
        cyc(8);
        check_cnt("t5_cnt04", 8'h04);
        check("t5_glitch", 8'(state), 8'd1);
        cyc(40);
        check_cnt("t5_cnt00", 8'h00);
        cyc(9);
        check("t5_pre", 8'(state), 8'd1);
        cyc(1);
        check("t5_done", 8'(state), 8'd3);
        check("t5_timeout", 8'(timeout), 8'd1);
        check("t5_winner", 8'(winner), 8'd0);
        check("t5_led", 8'(led), 8'd0);
        cyc(15);
        check_cnt("t5_frozen", 8'h00);

        // Asynchronous clear mid-ARMED, then restart
        pulse_start();
        cyc(23);
        check_cnt("t6_cnt03", 8'h03);
        clr = 1'b0;
        #2;
        check("t6_state", 8'(state), 8'd0);
        check("t6_winner", 8'(winner), 8'd0);
        check("t6_led", 8'(led), 8'd0);
        check_cnt("t6_cnt", 8'h05);
        check("t6_timeout", 8'(timeout), 8'd0);
        cyc(2);
        clr = 1'b1;
        cyc(2);
        pulse_start();
        check("t6_restart", 8'(state), 8'd1);
        check_cnt("t6_restart_cnt", 8'h05);
        cyc(10);
        check_cnt("t6_tick", 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
